// File: rtl/updi_pkg.sv
// Shared UPDI types and defaults: bridge modes, link sequencer states,
// timing defaults and the phase-selection helper.
package updi_pkg;

  localparam int UPDI_LEN_W = 4;

  localparam int UPDI_BREAK_CYCLES      = 24000;
  localparam int UPDI_RELEASE_CYCLES    = 2000;
  localparam int UPDI_GUARD_CYCLES      = 400;
  localparam int UPDI_RX_TIMEOUT_CYCLES = 60000;
  localparam int UPDI_CNT_W             = 16;

  typedef enum logic [1:0] {
    BRIDGE_IDLE,
    BRIDGE_TX,
    BRIDGE_RX,
    BRIDGE_BREAK
  } updi_bridge_mode;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_BREAK,
    SEQ_RELEASE,
    SEQ_TX,
    SEQ_GUARD,
    SEQ_RX,
    SEQ_FINISH
  } updi_seq_state;

  // First data phase still owed: TX, then RX, else straight to FINISH.
  function automatic updi_seq_state seq_data_phase(
    input logic [UPDI_LEN_W-1:0] tx_len,
    input logic [UPDI_LEN_W-1:0] rx_len
  );
    if (tx_len != '0) return SEQ_TX;
    if (rx_len != '0) return SEQ_RX;
    return SEQ_FINISH;
  endfunction

endpackage

// File: rtl/updi_seq_timer.sv
// Loadable down-counter shared by the BREAK, RELEASE, GUARD and RX
// timeout phases; holds at zero once expired.
module updi_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/updi_link_sequencer.sv
// UPDI link phase sequencer: BREAK, release, TX, guard and RX phases,
// driving the bridge controller's override and write-enable controls.
module updi_link_sequencer
  import updi_pkg::*;
#(
  parameter int BREAK_CYCLES      = UPDI_BREAK_CYCLES,
  parameter int RELEASE_CYCLES    = UPDI_RELEASE_CYCLES,
  parameter int GUARD_CYCLES      = UPDI_GUARD_CYCLES,
  parameter int RX_TIMEOUT_CYCLES = UPDI_RX_TIMEOUT_CYCLES,
  parameter int CNT_W             = UPDI_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_break,
  input  logic [UPDI_LEN_W-1:0] cmd_tx_len,
  input  logic [UPDI_LEN_W-1:0] cmd_rx_len,
  output logic                  tx_go,
  input  logic                  tx_byte_done,
  input  logic                  rx_byte_valid,
  output logic                  wr_en,
  output logic                  override_en,
  output logic                  override_value,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] BRK_LD = CNT_W'(BREAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LD = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRD_LD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RXT_LD = CNT_W'(RX_TIMEOUT_CYCLES - 1);
  localparam logic [UPDI_LEN_W-1:0] LEN_ONE = UPDI_LEN_W'(1);

  updi_seq_state state_q, state_d;
  logic [UPDI_LEN_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [UPDI_LEN_W-1:0] rx_cnt_q, rx_cnt_d;
  logic                  to_q, to_d;
  logic                  t_load;
  logic [CNT_W-1:0]      t_val;
  logic                  t_zero;

  updi_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_comb begin
    state_d  = state_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    to_d     = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (cmd_valid) begin
          tx_cnt_d = cmd_tx_len;
          rx_cnt_d = cmd_rx_len;
          state_d  = cmd_break ? SEQ_BREAK
                   : seq_data_phase(cmd_tx_len, cmd_rx_len);
        end
      end
      SEQ_BREAK: begin
        if (t_zero) state_d = SEQ_RELEASE;
      end
      SEQ_RELEASE: begin
        if (t_zero) state_d = seq_data_phase(tx_cnt_q, rx_cnt_q);
      end
      SEQ_TX: begin
        if (tx_byte_done && tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - LEN_ONE;
        end
        if (tx_cnt_d == '0) state_d = SEQ_GUARD;
      end
      SEQ_GUARD: begin
        if (t_zero) state_d = seq_data_phase('0, rx_cnt_q);
      end
      SEQ_RX: begin
        if (rx_byte_valid && rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - LEN_ONE;
          t_load   = 1'b1;
          t_val    = RXT_LD;
        end
        // A byte landing on the expiry cycle beats the timeout.
        if (rx_cnt_d == '0) begin
          state_d = SEQ_FINISH;
        end else if (t_zero && !rx_byte_valid) begin
          to_d    = 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      SEQ_FINISH: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      unique case (state_d)
        SEQ_BREAK:   begin t_load = 1'b1; t_val = BRK_LD; end
        SEQ_RELEASE: begin t_load = 1'b1; t_val = REL_LD; end
        SEQ_GUARD:   begin t_load = 1'b1; t_val = GRD_LD; end
        SEQ_RX:      begin t_load = 1'b1; t_val = RXT_LD; end
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      to_q     <= to_d;
    end
  end

  assign cmd_ready      = (state_q == SEQ_IDLE);
  assign busy           = (state_q != SEQ_IDLE);
  assign override_en    = (state_q != SEQ_TX) && (state_q != SEQ_RX);
  assign override_value = (state_q != SEQ_BREAK);
  assign wr_en          = (state_q == SEQ_TX);
  assign tx_go          = (state_q == SEQ_TX);
  assign done           = (state_q == SEQ_FINISH);
  assign timeout_err    = to_q;

endmodule

// File: tb/tb_updi_link_sequencer.sv
// Self-checking bench for updi_link_sequencer: table of transactions with
// a scoreboard of expected completion events, plus reset/corner sequences.
module tb_updi_link_sequencer;

  localparam int B   = 10;
  localparam int R   = 5;
  localparam int G   = 8;
  localparam int RXT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_break = 1'b0;
  logic [3:0] cmd_tx_len = '0;
  logic [3:0] cmd_rx_len = '0;
  logic       tx_go;
  logic       tx_byte_done = 1'b0;
  logic       rx_byte_valid = 1'b0;
  logic       wr_en;
  logic       override_en;
  logic       override_value;
  logic       done;
  logic       timeout_err;
  logic       busy;

  updi_link_sequencer #(
    .BREAK_CYCLES      (B),
    .RELEASE_CYCLES    (R),
    .GUARD_CYCLES      (G),
    .RX_TIMEOUT_CYCLES (RXT),
    .CNT_W             (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_break      (cmd_break),
    .cmd_tx_len     (cmd_tx_len),
    .cmd_rx_len     (cmd_rx_len),
    .tx_go          (tx_go),
    .tx_byte_done   (tx_byte_done),
    .rx_byte_valid  (rx_byte_valid),
    .wr_en          (wr_en),
    .override_en    (override_en),
    .override_value (override_value),
    .done           (done),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int failed    = 0;

  typedef struct {
    int kind;
    int edge_n;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int brk;
    int tx;
    int rx;
    int sup;
    int gap;
    int noise;
  } vec_t;
  vec_t vecs[11];

  int ovl_n = 0;
  int wr_n  = 0;
  int go_n  = 0;
  int hi_n  = 0;

  always @(negedge clk) begin
    exp_t e;
    int act;
    if (!override_value) ovl_n++;
    if (wr_en) wr_n++;
    if (tx_go) go_n++;
    if (busy && override_en && override_value && !done) hi_n++;
    if (done || timeout_err) begin
      act = (timeout_err ? 2 : 0) + (done ? 1 : 0);
      tests_run++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL outcome_spurious: kind=%0d at edge %0d, none expected",
                 act, cyc);
      end else begin
        e = sb.pop_front();
        if (act != e.kind || cyc != e.edge_n) begin
          failed++;
          $display("FAIL outcome: kind=%0d edge=%0d, expected kind=%0d edge=%0d",
                   act, cyc, e.kind, e.edge_n);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_at(input int e, input bit is_tx, input bit is_rx);
    while (cyc < e - 1) tick();
    tx_byte_done  = is_tx;
    rx_byte_valid = is_rx;
    tick();
    tx_byte_done  = 1'b0;
    rx_byte_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    chk({tag, "_override_en"}, int'(override_en), 1);
    chk({tag, "_override_value"}, int'(override_value), 1);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_tx_go"}, int'(tx_go), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic run(input vec_t v, input int idx);
    int ts, e, rs, pos, cnt, xe, kind, last, fin;
    int s_ovl, s_wr, s_go, s_hi;
    exp_t x;
    if (v.noise != 0) pulse_at(cyc + 1, 1'b1, 1'b1);
    s_ovl = ovl_n; s_wr = wr_n; s_go = go_n; s_hi = hi_n;
    ts = cyc + 1;
    if (v.brk != 0) ts += B + R;
    e  = ts + 3 * v.tx;
    rs = (v.tx != 0) ? e + G : ts;
    if (v.rx == 0) begin
      kind = 1;
      xe   = rs;
    end else begin
      pos = rs;
      cnt = v.rx;
      for (int i = 1; i <= v.sup; i++) begin
        if (v.gap <= RXT) begin
          pos += v.gap;
          cnt--;
        end
      end
      kind = (cnt == 0) ? 1 : 2;
      xe   = (cnt == 0) ? pos : pos + RXT;
    end
    x.kind = kind;
    x.edge_n = xe;
    sb.push_back(x);

    cmd_break  = (v.brk != 0);
    cmd_tx_len = 4'(v.tx);
    cmd_rx_len = 4'(v.rx);
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;

    for (int i = 1; i <= v.tx; i++) pulse_at(ts + 3 * i, 1'b1, 1'b0);
    if (v.noise != 0 && v.tx != 0) begin
      while (cyc < e + 1) tick();
      chk($sformatf("v%0d_ready_busy", idx), int'(cmd_ready), 0);
      cmd_break  = 1'b0;
      cmd_tx_len = 4'd0;
      cmd_rx_len = 4'd0;
      cmd_valid  = 1'b1;
      pulse_at(e + 2, 1'b1, 1'b1);
      cmd_valid  = 1'b0;
    end
    last = 0;
    for (int i = 1; i <= v.sup; i++) begin
      last = rs + v.gap * i;
      pulse_at(last, 1'b0, 1'b1);
    end
    fin = (xe + 2 > last + 1) ? xe + 2 : last + 1;
    while (cyc < fin) tick();

    tests_run++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL v%0d_outcome_missing: %0d events pending, expected 0",
               idx, sb.size());
      sb.delete();
    end
    chk($sformatf("v%0d_low_cycles", idx), ovl_n - s_ovl,
        (v.brk != 0) ? B : 0);
    chk($sformatf("v%0d_wr_en_cycles", idx), wr_n - s_wr, 3 * v.tx);
    chk($sformatf("v%0d_tx_go_cycles", idx), go_n - s_go, 3 * v.tx);
    chk($sformatf("v%0d_idle_high_cycles", idx), hi_n - s_hi,
        ((v.brk != 0) ? R : 0) + ((v.tx != 0) ? G : 0));
  endtask

  initial begin
    vecs[0]  = '{brk: 1, tx: 0, rx: 0,  sup: 0,  gap: 4,  noise: 0};
    vecs[1]  = '{brk: 0, tx: 3, rx: 2,  sup: 2,  gap: 4,  noise: 0};
    vecs[2]  = '{brk: 0, tx: 0, rx: 4,  sup: 1,  gap: 4,  noise: 0};
    vecs[3]  = '{brk: 0, tx: 0, rx: 0,  sup: 0,  gap: 4,  noise: 0};
    vecs[4]  = '{brk: 1, tx: 2, rx: 1,  sup: 1,  gap: 4,  noise: 0};
    vecs[5]  = '{brk: 0, tx: 1, rx: 0,  sup: 0,  gap: 4,  noise: 1};
    vecs[6]  = '{brk: 0, tx: 0, rx: 15, sup: 15, gap: 4,  noise: 0};
    vecs[7]  = '{brk: 0, tx: 0, rx: 3,  sup: 0,  gap: 4,  noise: 0};
    vecs[8]  = '{brk: 0, tx: 0, rx: 2,  sup: 2,  gap: 50, noise: 0};
    vecs[9]  = '{brk: 0, tx: 0, rx: 1,  sup: 1,  gap: 51, noise: 0};
    vecs[10] = '{brk: 0, tx: 2, rx: 2,  sup: 2,  gap: 4,  noise: 1};

    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("por");
    rst = 1'b0;
    tick();

    cmd_break  = 1'b1;
    cmd_tx_len = 4'd2;
    cmd_rx_len = 4'd2;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    repeat (4) tick();
    chk("mid_break_low", int'(override_value), 0);
    chk("mid_break_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("mid_break_rst");
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    repeat (30) tick();
    chk("post_rst_still_idle", int'(busy), 0);

    for (int i = 0; i < 11; i++) run(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
